// File: rtl/ev21_pkg.sv
// Shared constants and types for the EV21 fetch-path program-counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ev21_pkg;

    // Default program address width and return-stack depth.
    localparam int EV21_AW    = 10;
    localparam int EV21_DEPTH = 8;

    // Instruction encodings that the decoder turns into bsr_det / ret_det.
    localparam logic [11:0] EV21_BSR_OPC  = 12'b011100000000;
    localparam logic [21:0] EV21_RET_WORD = 22'b0000011000000000000000;

    // Sequencer states: RUN fetches sequentially, FLUSH squashes the slot
    // behind a taken call/return, HALT parks the core after a stack fault.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: ring buffer plus occupancy count, combinational top-of-stack read.
// Latency: push/pop take effect at the next rising edge; dout reflects the current top.
// Backpressure: none; with wrap_i=1 overflow overwrites the oldest entry, otherwise overflow/underflow are ignored.
module ret_stack
    import ev21_pkg::*;
#(
    parameter int AW    = EV21_AW,
    parameter int DEPTH = EV21_DEPTH,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic           wrap_i,
    input  logic [AW-1:0]  din_i,
    output logic [AW-1:0]  dout_o,
    output logic [SPW-1:0] sp_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wp_q, wp_d;
    logic [PW-1:0]  rd_ptr;
    logic [SPW-1:0] sp_q, sp_d;
    logic           do_wr;

    // The write pointer always sits one above the top entry, so the top is wp-1.
    assign rd_ptr  = wp_q - PW'(1);
    assign dout_o  = mem_q[rd_ptr];
    assign sp_o    = sp_q;
    assign full_o  = (sp_q == SPW'(DEPTH));
    assign empty_o = (sp_q == '0);

    // Pointer and count update; in wrap mode the ring keeps moving past full/empty
    // while the count saturates at DEPTH / 0.
    always_comb begin
        wp_d  = wp_q;
        sp_d  = sp_q;
        do_wr = 1'b0;
        if (push_i) begin
            if (!full_o) begin
                do_wr = 1'b1;
                wp_d  = wp_q + PW'(1);
                sp_d  = sp_q + SPW'(1);
            end else if (wrap_i) begin
                do_wr = 1'b1;
                wp_d  = wp_q + PW'(1);
            end
        end else if (pop_i) begin
            if (!empty_o) begin
                wp_d = rd_ptr;
                sp_d = sp_q - SPW'(1);
            end else if (wrap_i) begin
                wp_d = rd_ptr;
            end
        end
    end

    // Pointer/count registers; the storage array itself is not reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q <= '0;
            sp_q <= '0;
        end else begin
            wp_q <= wp_d;
            sp_q <= sp_d;
        end
    end

    // Entry storage, written at the current write pointer.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wp_q] <= din_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// EV21 program-counter sequencer: sequential fetch, BSR/RET with return stack, one-slot flush.
// Latency: taken BSR/RET loads the new pc at the next edge; one squashed slot follows.
// Backpressure: hold=1 freezes every register. Build option EV21_STACK_GUARD_EN halts on stack over/underflow.
module pc_sequencer
    import ev21_pkg::*;
#(
    parameter int AW    = EV21_AW,
    parameter int DEPTH = EV21_DEPTH,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           hold,
    input  logic           bsr_det,
    input  logic           ret_det,
    input  logic [9:0]     relative_jump,
    output logic [AW-1:0]  pc,
    output logic           flush,
    output logic [SPW-1:0] sp,
    output logic           stack_full,
    output logic           stack_empty,
    output logic           err
);

`ifdef EV21_STACK_GUARD_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif

    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic          err_q, err_d;
    logic          push, pop;
    logic [AW-1:0] offset;
    logic [AW-1:0] bsr_tgt;
    logic [AW-1:0] link_addr;
    logic [AW-1:0] stk_dout;

    // Offset is sign-extended; all target arithmetic wraps modulo 2^AW.
    assign offset    = AW'($signed(relative_jump));
    assign bsr_tgt   = ir_pc_q + offset;
    assign link_addr = ir_pc_q + AW'(1);

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_ret_stack (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .wrap_i  (~GUARD_EN),
        .din_i   (link_addr),
        .dout_o  (stk_dout),
        .sp_o    (sp),
        .full_o  (stack_full),
        .empty_o (stack_empty)
    );

    // Next-state decode; ret wins over bsr, and a guarded fault parks in HALT without moving pc.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_pc_d = ir_pc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!hold) begin
            case (state_q)
                ST_RUN: begin
                    ir_pc_d = pc_q;
                    if (ret_det) begin
                        if (GUARD_EN && stack_empty) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pop     = 1'b1;
                            pc_d    = stk_dout;
                            state_d = ST_FLUSH;
                        end
                    end else if (bsr_det) begin
                        if (GUARD_EN && stack_full) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            push    = 1'b1;
                            pc_d    = bsr_tgt;
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
                ST_FLUSH: begin
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + AW'(1);
                    state_d = ST_RUN;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_FLUSH;
                end
            endcase
        end
    end

    // State registers; reset restarts fetch at 0 with the first slot flushed.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_FLUSH;
            pc_q    <= '0;
            ir_pc_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_pc_q <= ir_pc_d;
            err_q   <= err_d;
        end
    end

    assign pc    = pc_q;
    assign flush = (state_q != ST_RUN);
    assign err   = err_q;

endmodule
